calc_btn_cond: RTL and testbench

//  Input-conditioning stage that sits directly upstream of the calculator datapath.

---
 rtl/calc_pkg.sv | 22 ++
 rtl/calc_btn_cond_if.sv | 31 +++
 rtl/calc_btn_cond_debounce.sv | 65 ++++++
 rtl/calc_btn_cond.sv | 67 ++++++
 tb/tb_calc_btn_cond.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calculator front end: debounce depths and button indices.
// Button vectors everywhere are indexed with the BTN_* constants below.
package calc_pkg;

    localparam int DEB_CYCLES_SIM   = 16;
    localparam int DEB_CYCLES_BOARD = 1_000_000;

    localparam int BTN_C   = 0;
    localparam int BTN_AC  = 1;
    localparam int BTN_L   = 2;
    localparam int BTN_R   = 3;
    localparam int BTN_D   = 4;
    localparam int NUM_BTN = 5;

    typedef logic [NUM_BTN-1:0] btn_vec_t;

    // Counter width that can hold DEB_CYCLES-1 without wrapping.
    function automatic int deb_cnt_w(input int deb_cycles);
        return (deb_cycles > 1) ? $clog2(deb_cycles) : 1;
    endfunction

endpackage

// File: rtl/calc_btn_cond_if.sv
// Raw board inputs and conditioned outputs of the calculator input stage.
// master drives the raw side (board/bench), slave is the conditioning block.
interface calc_btn_cond_if #(
    parameter int SW_W = 16
);

    logic            btnc_raw;
    logic            btnac_raw;
    logic            btnl_raw;
    logic            btnr_raw;
    logic            btnd_raw;
    logic [SW_W-1:0] sw_raw;

    logic            btnc_pulse;
    logic            btnac_pulse;
    logic            btnl_lvl;
    logic            btnr_lvl;
    logic            btnd_lvl;
    logic [SW_W-1:0] sw_sync;

    modport master (
        output btnc_raw, btnac_raw, btnl_raw, btnr_raw, btnd_raw, sw_raw,
        input  btnc_pulse, btnac_pulse, btnl_lvl, btnr_lvl, btnd_lvl, sw_sync
    );

    modport slave (
        input  btnc_raw, btnac_raw, btnl_raw, btnr_raw, btnd_raw, sw_raw,
        output btnc_pulse, btnac_pulse, btnl_lvl, btnr_lvl, btnd_lvl, sw_sync
    );

endinterface

// File: rtl/calc_btn_cond_debounce.sv
// One button: 2-FF sync, stability counter, accepted level and registered rising-edge pulse.
// Level follows raw 2+DEB_CYCLES edges after a clean change; pulse one edge later; no backpressure.
module calc_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    import calc_pkg::*;

    localparam int CNT_W = deb_cnt_w(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q, stable_dly_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d         = raw;
        s2_d         = s1_q;
        stable_d     = stable_q;
        cnt_d        = cnt_q;
        stable_dly_d = stable_q;
        pulse_d      = stable_q & ~stable_dly_q;

        // Any sample matching the accepted level restarts the stability window.
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            pulse_q      <= pulse_d;
            cnt_q        <= cnt_d;
        end
    end

    assign level      = stable_q;
    assign rise_pulse = pulse_q;

endmodule

// File: rtl/calc_btn_cond.sv
// Conditions the five buttons (debounced levels, commit/clear pulses) and synchronises the switches.
// Levels 2+DEB_CYCLES edges, pulses 3+DEB_CYCLES edges, switches 2 edges; no backpressure.
module calc_btn_cond #(
    parameter int DEB_CYCLES = 16,
    parameter int SW_W       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    calc_btn_cond_if.slave btn_if
);

    import calc_pkg::*;

    btn_vec_t        raw_vec;
    btn_vec_t        lvl_vec;
    btn_vec_t        rise_vec;
    logic            unused_rise;
    logic [SW_W-1:0] sw_s1_q, sw_s1_d;
    logic [SW_W-1:0] sw_s2_q, sw_s2_d;

    assign raw_vec[BTN_C]  = btn_if.btnc_raw;
    assign raw_vec[BTN_AC] = btn_if.btnac_raw;
    assign raw_vec[BTN_L]  = btn_if.btnl_raw;
    assign raw_vec[BTN_R]  = btn_if.btnr_raw;
    assign raw_vec[BTN_D]  = btn_if.btnd_raw;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        calc_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw        (raw_vec[i]),
            .level      (lvl_vec[i]),
            .rise_pulse (rise_vec[i])
        );
    end

    // Op-select buttons are consumed as levels only; their edge pulses are dropped.
    assign unused_rise = ^{rise_vec[BTN_L], rise_vec[BTN_R], rise_vec[BTN_D]};

    // Commit and clear are independent; the datapath resolves btnac priority.
    assign btn_if.btnc_pulse  = rise_vec[BTN_C];
    assign btn_if.btnac_pulse = rise_vec[BTN_AC];
    assign btn_if.btnl_lvl    = lvl_vec[BTN_L];
    assign btn_if.btnr_lvl    = lvl_vec[BTN_R];
    assign btn_if.btnd_lvl    = lvl_vec[BTN_D];

    // Switches are only sampled on a commit pulse, so bounce on them is harmless.
    always_comb begin
        sw_s1_d = btn_if.sw_raw;
        sw_s2_d = sw_s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= sw_s1_d;
            sw_s2_q <= sw_s2_d;
        end
    end

    assign btn_if.sw_sync = sw_s2_q;

endmodule

// File: tb/tb_calc_btn_cond.sv
// Directed bench for calc_btn_cond at DEB_CYCLES=4: a per-edge vector table for the clean
// press and switch path, then hand sequences for glitches, ops+commit, simultaneity and reset.
module tb_calc_btn_cond;

    localparam int DEB = 4;

    typedef struct {
        logic [4:0]  btn;       // {d, r, l, ac, c}
        logic [15:0] sw;
        logic [1:0]  exp_pulse; // {ac, c}
        logic [2:0]  exp_lvl;   // {l, r, d}
        logic [15:0] exp_sw;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   cnt_pulse;
    vec_t vecs[30];

    calc_btn_cond_if #(.SW_W(16)) bus ();

    calc_btn_cond #(
        .DEB_CYCLES (DEB),
        .SW_W       (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] b);
        bus.btnc_raw  = b[0];
        bus.btnac_raw = b[1];
        bus.btnl_raw  = b[2];
        bus.btnr_raw  = b[3];
        bus.btnd_raw  = b[4];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] pulses();
        return {bus.btnac_pulse, bus.btnc_pulse};
    endfunction

    function automatic logic [2:0] lvls();
        return {bus.btnl_lvl, bus.btnr_lvl, bus.btnd_lvl};
    endfunction

    initial begin
        n_chk  = 0;
        n_pass = 0;

        // Row i is applied before edge i+1: btnc held 20 edges, sw changes before edge 10.
        for (int i = 0; i < 30; i++) begin
            vecs[i].btn       = (i < 20) ? 5'b00001 : 5'b00000;
            vecs[i].sw        = (i < 9) ? 16'h8001 : 16'h1234;
            vecs[i].exp_pulse = (i == 6) ? 2'b01 : 2'b00;
            vecs[i].exp_lvl   = 3'b000;
            vecs[i].exp_sw    = (i == 0) ? 16'h0000 : ((i < 10) ? 16'h8001 : 16'h1234);
        end

        // Reset with inputs active: nothing may leak through.
        rst_n      = 1'b0;
        drive(5'b11111);
        bus.sw_raw = 16'h8001;
        #2;
        chk("reset_async_sw", 32'(bus.sw_sync), 32'h0);
        repeat (3) step();
        chk("reset_pulse", 32'(pulses()), 32'h0);
        chk("reset_lvl", 32'(lvls()), 32'h0);
        chk("reset_sw", 32'(bus.sw_sync), 32'h0);

        // Switch path out of reset: visible after exactly two edges.
        drive(5'b00000);
        rst_n = 1'b1;
        step();
        chk("sw_edge1", 32'(bus.sw_sync), 32'h0);
        step();
        chk("sw_edge2", 32'(bus.sw_sync), 32'h8001);
        bus.sw_raw = 16'h0000;
        repeat (4) step();
        chk("sw_idle", 32'(bus.sw_sync), 32'h0);
        chk("idle_lvl", 32'(lvls()), 32'h0);

        // Clean press: single pulse between edges 7 and 8, none on release.
        for (int i = 0; i < 30; i++) begin
            drive(vecs[i].btn);
            bus.sw_raw = vecs[i].sw;
            step();
            chk($sformatf("tbl_pulse[%0d]", i), 32'(pulses()), 32'(vecs[i].exp_pulse));
            chk($sformatf("tbl_lvl[%0d]", i), 32'(lvls()), 32'(vecs[i].exp_lvl));
            chk($sformatf("tbl_sw[%0d]", i), 32'(bus.sw_sync), 32'(vecs[i].exp_sw));
        end
        bus.sw_raw = 16'h0000;
        repeat (10) step();

        // Glitch: three cycles high never reaches acceptance.
        for (int k = 0; k < 11; k++) begin
            drive((k < 3) ? 5'b00100 : 5'b00000);
            step();
            chk($sformatf("glitch_l[%0d]", k), 32'(bus.btnl_lvl), 32'h0);
        end

        // Bounce 1,0,1,1,...: the dip restarts the count, so the level rises after edge 8.
        for (int k = 0; k < 12; k++) begin
            drive((k == 1) ? 5'b00000 : 5'b00100);
            step();
            chk($sformatf("bounce_l[%0d]", k), 32'(bus.btnl_lvl), (k >= 7) ? 32'h1 : 32'h0);
        end
        drive(5'b00000);
        repeat (10) step();
        chk("bounce_release", 32'(lvls()), 32'h0);

        // Op select settled, then commit: levels must be 110 whenever the pulse fires.
        drive(5'b01100);
        repeat (8) step();
        chk("ops_settled", 32'(lvls()), 32'h6);
        drive(5'b01101);
        cnt_pulse = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("ops_lvl[%0d]", k), 32'(lvls()), 32'h6);
            if (bus.btnc_pulse === 1'b1) cnt_pulse++;
        end
        chk("ops_pulse_count", 32'(cnt_pulse), 32'h1);
        drive(5'b00000);
        repeat (10) step();

        // Simultaneous commit and clear: both pulse in the same single cycle.
        drive(5'b00011);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("simul[%0d]", k), 32'(pulses()), (k == 6) ? 32'h3 : 32'h0);
        end
        drive(5'b00000);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("release[%0d]", k), 32'(pulses()), 32'h0);
        end

        // Reset mid-count with btnc held: full acceptance restarts after release.
        drive(5'b00001);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("pre_rst[%0d]", k), 32'(pulses()), 32'h0);
        end
        rst_n = 1'b0;
        repeat (2) step();
        chk("mid_rst_pulse", 32'(pulses()), 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("post_rst[%0d]", k), 32'(bus.btnc_pulse), (k == 6) ? 32'h1 : 32'h0);
        end

        // Reset during the pulse cycle drops it at once; a fresh pulse follows release.
        drive(5'b00000);
        repeat (10) step();
        drive(5'b00001);
        repeat (7) step();
        chk("inflight_pulse", 32'(bus.btnc_pulse), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("inflight_drop", 32'(bus.btnc_pulse), 32'h0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("refire[%0d]", k), 32'(bus.btnc_pulse), (k == 6) ? 32'h1 : 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
